// File: rtl/serial_addsub_pkg.sv
// Shared types and sizing helpers for the digit-serial adder/subtractor.
// Optional feature macro: SERIAL_ADDSUB_OVF_EN (adds the signed-overflow flag).
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of RUN cycles needed to walk all digits of an operand.
    function automatic int calc_ndig(input int width, input int digit);
        return width / digit;
    endfunction

    // Width of a counter able to hold 0..ndig.
    function automatic int calc_cw(input int ndig);
        return $clog2(ndig + 1);
    endfunction

endpackage

// File: rtl/serial_addsub_unit_digit_adder.sv
// Combinational DIGIT-bit ripple-carry adder used once per RUN cycle.
// With SERIAL_ADDSUB_OVF_EN defined it also exposes the carry into its top bit,
// which the top level uses to detect signed overflow on the final digit.
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    output logic             c_msb_in
`endif
);

    logic [DIGIT:0] carry_s;

    // Ripple the carry through the digit one bit at a time.
    always_comb begin
        carry_s    = {(DIGIT + 1){1'b0}};
        s          = {DIGIT{1'b0}};
        carry_s[0] = ci;
        for (int i = 0; i < DIGIT; i++) begin
            s[i]           = a[i] ^ b[i] ^ carry_s[i];
            carry_s[i + 1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
        end
    end

    assign co = carry_s[DIGIT];

`ifdef SERIAL_ADDSUB_OVF_EN
    assign c_msb_in = carry_s[DIGIT-1];
`endif

endmodule

// File: rtl/serial_addsub_unit.sv
// Digit-serial adder/subtractor: WIDTH-bit operands, DIGIT bits per clock,
// least-significant digit first, with a start/busy/done handshake.
// Optional feature macro: SERIAL_ADDSUB_OVF_EN (adds the ovf port).
module serial_addsub_unit
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] adata,
    input  logic [WIDTH-1:0] bdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] pout,
    output logic             cout
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int             NDIG     = calc_ndig(WIDTH, DIGIT);
    localparam int             CW       = calc_cw(NDIG);
    localparam logic [CW-1:0]  LAST_CNT = CW'(NDIG - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             sub_q, sub_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] pout_q, pout_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic             ovf_q, ovf_d;
    logic             c_msb_s;
`endif

    logic [DIGIT-1:0] b_dig_s;
    logic [DIGIT-1:0] sum_s;
    logic             co_s;
    logic [WIDTH-1:0] r_next_s;
    logic             load_s;
    logic             last_s;

    // For subtraction B is inverted digit by digit; the +1 comes from carry-in.
    assign b_dig_s = b_q[DIGIT-1:0] ^ {DIGIT{sub_q}};

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit_adder (
        .a        (a_q[DIGIT-1:0]),
        .b        (b_dig_s),
        .ci       (c_q),
        .s        (sum_s),
        .co       (co_s)
`ifdef SERIAL_ADDSUB_OVF_EN
        ,
        .c_msb_in (c_msb_s)
`endif
    );

    // New sum digit enters at the top so the LSB digit ends at bit 0 after NDIG shifts.
    assign r_next_s = (r_q >> DIGIT) | (WIDTH'(sum_s) << (WIDTH - DIGIT));

    assign load_s = start & ((state_q == IDLE) | (state_q == DONE));
    assign last_s = (state_q == RUN) & (cnt_q == LAST_CNT);

    // Next-state logic: start is only honoured while not running.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (start) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand/result shift registers, carry and digit counter.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        r_d   = r_q;
        sub_d = sub_q;
        c_d   = c_q;
        cnt_d = cnt_q;
        if (load_s) begin
            a_d   = adata;
            b_d   = bdata;
            r_d   = {WIDTH{1'b0}};
            sub_d = sub;
            c_d   = sub;
            cnt_d = {CW{1'b0}};
        end else if (state_q == RUN) begin
            a_d   = a_q >> DIGIT;
            b_d   = b_q >> DIGIT;
            r_d   = r_next_s;
            c_d   = co_s;
            cnt_d = cnt_q + CW'(1);
        end else begin
            a_d   = a_q;
            b_d   = b_q;
        end
    end

    // Output registers: result captured only on the final RUN cycle, flags from next state.
    always_comb begin
        pout_d = pout_q;
        cout_d = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
        ovf_d  = ovf_q;
`endif
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
        if (last_s) begin
            pout_d = r_next_s;
            cout_d = co_s;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf_d  = co_s ^ c_msb_s;
`endif
        end else begin
            pout_d = pout_q;
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            r_q     <= {WIDTH{1'b0}};
            sub_q   <= 1'b0;
            c_q     <= 1'b0;
            cnt_q   <= {CW{1'b0}};
            pout_q  <= {WIDTH{1'b0}};
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            sub_q   <= sub_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            pout_q  <= pout_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign pout = pout_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Directed bench for serial_addsub_unit: a W8/D1 instance and a W16/D4 instance.
module tb_serial_addsub_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start0 = 1'b0, sub0 = 1'b0;
    logic [7:0]  a0 = 8'h00, b0 = 8'h00;
    logic        busy0, done0, cout0;
    logic [7:0]  pout0;

    logic        start1 = 1'b0, sub1 = 1'b0;
    logic [15:0] a1 = 16'h0000, b1 = 16'h0000;
    logic        busy1, done1, cout1;
    logic [15:0] pout1;

`ifdef SERIAL_ADDSUB_OVF_EN
    logic        ovf0, ovf1;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_addsub_unit #(.WIDTH(8), .DIGIT(1)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .sub(sub0), .adata(a0), .bdata(b0),
        .busy(busy0), .done(done0), .pout(pout0), .cout(cout0)
`ifdef SERIAL_ADDSUB_OVF_EN
        , .ovf(ovf0)
`endif
    );

    serial_addsub_unit #(.WIDTH(16), .DIGIT(4)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .sub(sub1), .adata(a1), .bdata(b1),
        .busy(busy1), .done(done1), .pout(pout1), .cout(cout1)
`ifdef SERIAL_ADDSUB_OVF_EN
        , .ovf(ovf1)
`endif
    );

    // Called #1 after a rising edge: present operands, let the next edge accept them.
    task automatic start_op0(input logic [7:0] a, input logic [7:0] b, input logic s);
        start0 = 1'b1; a0 = a; b0 = b; sub0 = s;
        @(posedge clk); #1;
        start0 = 1'b0;
    endtask

    task automatic start_op1(input logic [15:0] a, input logic [15:0] b, input logic s);
        start1 = 1'b1; a1 = a; b1 = b; sub1 = s;
        @(posedge clk); #1;
        start1 = 1'b0;
    endtask

    // Count edges after the accepting edge until done; bounded.
    task automatic wait_done0(output int lat);
        lat = 0;
        while (done0 !== 1'b1 && lat < 64) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic wait_done1(output int lat);
        lat = 0;
        while (done1 !== 1'b1 && lat < 64) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin failures++; $display("FAIL reset_flags0 busy=%b done=%b exp 0 0", busy0, done0); end
        checks++; if (pout0 !== 8'h00 || cout0 !== 1'b0) begin failures++; $display("FAIL reset_out0 pout=%h cout=%b exp 00 0", pout0, cout0); end
        checks++; if (busy1 !== 1'b0 || pout1 !== 16'h0000) begin failures++; $display("FAIL reset_dut1 busy=%b pout=%h exp 0 0000", busy1, pout1); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_add_basic;
        int lat;
        start_op0(8'h01, 8'h02, 1'b0);
        checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL add_busy got=%b exp=1", busy0); end
        wait_done0(lat);
        checks++; if (lat != 8) begin failures++; $display("FAIL add_latency got=%0d exp=8", lat); end
        checks++; if (pout0 !== 8'h03 || cout0 !== 1'b0) begin failures++; $display("FAIL add_result pout=%h cout=%b exp 03 0", pout0, cout0); end
        checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL add_busy_done got=%b exp=0", busy0); end
        @(posedge clk); #1;
        checks++; if (done0 !== 1'b0 || pout0 !== 8'h03) begin failures++; $display("FAIL add_pulse done=%b pout=%h exp 0 03", done0, pout0); end
    endtask

    task automatic test_carry_ovf;
        int lat;
        start_op0(8'hFF, 8'h01, 1'b0);
        wait_done0(lat);
        checks++; if (pout0 !== 8'h00 || cout0 !== 1'b1) begin failures++; $display("FAIL carry_wrap pout=%h cout=%b exp 00 1", pout0, cout0); end
`ifdef SERIAL_ADDSUB_OVF_EN
        checks++; if (ovf0 !== 1'b0) begin failures++; $display("FAIL ovf_wrap got=%b exp=0", ovf0); end
`endif
        @(posedge clk); #1;
        start_op0(8'h7F, 8'h01, 1'b0);
        wait_done0(lat);
        checks++; if (pout0 !== 8'h80 || cout0 !== 1'b0) begin failures++; $display("FAIL signed_edge pout=%h cout=%b exp 80 0", pout0, cout0); end
`ifdef SERIAL_ADDSUB_OVF_EN
        checks++; if (ovf0 !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", ovf0); end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_sub;
        int lat;
        start_op0(8'h05, 8'h07, 1'b1);
        wait_done0(lat);
        checks++; if (pout0 !== 8'hFE || cout0 !== 1'b0) begin failures++; $display("FAIL sub_borrow pout=%h cout=%b exp FE 0", pout0, cout0); end
        @(posedge clk); #1;
        start_op0(8'h07, 8'h05, 1'b1);
        wait_done0(lat);
        checks++; if (pout0 !== 8'h02 || cout0 !== 1'b1) begin failures++; $display("FAIL sub_noborrow pout=%h cout=%b exp 02 1", pout0, cout0); end
        @(posedge clk); #1;
    endtask

    task automatic test_ignore_start;
        int lat;
        int extra;
        start_op0(8'h10, 8'h20, 1'b0);
        lat = 0;
        while (done0 !== 1'b1 && lat < 64) begin
            @(posedge clk); #1; lat++;
            if (lat == 2) begin start0 = 1'b1; a0 = 8'hAA; b0 = 8'h55; sub0 = 1'b1; end
            if (lat == 4) start0 = 1'b0;
        end
        checks++; if (lat != 8) begin failures++; $display("FAIL ignore_latency got=%0d exp=8", lat); end
        checks++; if (pout0 !== 8'h30 || cout0 !== 1'b0) begin failures++; $display("FAIL ignore_result pout=%h cout=%b exp 30 0", pout0, cout0); end
        extra = 0;
        repeat (12) begin @(posedge clk); #1; if (done0 === 1'b1) extra++; end
        checks++; if (extra != 0) begin failures++; $display("FAIL ignore_extra_done got=%0d exp=0", extra); end
    endtask

    task automatic test_reset_mid_run;
        int lat;
        int extra;
        start_op0(8'h11, 8'h22, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++; if (busy0 !== 1'b0 || pout0 !== 8'h00 || done0 !== 1'b0) begin failures++; $display("FAIL midrst busy=%b pout=%h done=%b exp 0 00 0", busy0, pout0, done0); end
        #2 rst = 1'b0;
        extra = 0;
        repeat (12) begin @(posedge clk); #1; if (done0 === 1'b1) extra++; end
        checks++; if (extra != 0) begin failures++; $display("FAIL midrst_done got=%0d exp=0", extra); end
        start_op0(8'h33, 8'h44, 1'b0);
        wait_done0(lat);
        checks++; if (lat != 8 || pout0 !== 8'h77) begin failures++; $display("FAIL midrst_next lat=%0d pout=%h exp 8 77", lat, pout0); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int lat;
        start_op1(16'h1234, 16'h0FFF, 1'b0);
        wait_done1(lat);
        checks++; if (lat != 4) begin failures++; $display("FAIL w16_latency got=%0d exp=4", lat); end
        checks++; if (pout1 !== 16'h2233 || cout1 !== 1'b0) begin failures++; $display("FAIL w16_result pout=%h cout=%b exp 2233 0", pout1, cout1); end
        start_op1(16'h8000, 16'h0001, 1'b1);
        checks++; if (busy1 !== 1'b1 || done1 !== 1'b0 || pout1 !== 16'h2233) begin failures++; $display("FAIL b2b_accept busy=%b done=%b pout=%h exp 1 0 2233", busy1, done1, pout1); end
        wait_done1(lat);
        checks++; if (lat != 4) begin failures++; $display("FAIL b2b_latency got=%0d exp=4", lat); end
        checks++; if (pout1 !== 16'h7FFF || cout1 !== 1'b1) begin failures++; $display("FAIL b2b_result pout=%h cout=%b exp 7fff 1", pout1, cout1); end
`ifdef SERIAL_ADDSUB_OVF_EN
        checks++; if (ovf1 !== 1'b1) begin failures++; $display("FAIL b2b_ovf got=%b exp=1", ovf1); end
`endif
        @(posedge clk); #1;
        checks++; if (done1 !== 1'b0 || busy1 !== 1'b0) begin failures++; $display("FAIL b2b_idle done=%b busy=%b exp 0 0", done1, busy1); end
    endtask

    initial begin
        test_reset;
        test_add_basic;
        test_carry_ovf;
        test_sub;
        test_ignore_start;
        test_reset_mid_run;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
